fft_frame_ctrl: RTL and testbench
=================================

Name: fft_frame_ctrl

Overview:
Frame sequencer between the ping-pong sample RAM and the 256-point FFT core. On each buffer-ready pulse it streams one buffer from RAM into the FFT, then drains all output bins. While draining it computes a per-bin magnitude and reports the peak bin and its magnitude once per frame. It queues one pending buffer, counts dropped buffers and frames, and aborts on an FFT watchdog timeout.

Parameters:
DATA_WIDTH, 24, FFT real/imag sample width
FFT_SIZE, 256, samples in per frame and bins out per frame (power of 2)
BIN_W, 8, log2(FFT_SIZE)
SKIP_DC, 1, 1 = exclude bin 0 from the peak search
TIMEOUT_CYC, 65535, maximum WAIT_FFT cycles before abort

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous reset, active-high
enable_i  in  1  allow new frames to start
buffer_ready_i  in  1  pulse: RAM buffer full
ram_valid_i  in  1  RAM read data valid
ram_ready_o  out  1  RAM read accept
fft_in_valid_o  out  1  FFT input valid
fft_in_ready_i  in  1  FFT input ready
fft_out_valid_i  in  1  FFT bin valid
fft_out_ready_o  out  1  bin accept
fft_real_i  in  DATA_WIDTH  signed bin real part
fft_imag_i  in  DATA_WIDTH  signed bin imaginary part
peak_bin_o  out  BIN_W  peak bin index of the last frame
peak_mag_o  out  MAG_W  peak magnitude of the last frame
frame_done_o  out  1  one-cycle pulse, peak outputs updated
frame_count_o  out  16  completed frames, wraps
drop_count_o  out  8  dropped buffers, saturates at 255
timeout_o  out  1  sticky watchdog flag
state_o  out  3  current state encoding, for debug LEDs

Behaviour:
- Reset values: all outputs 0; state IDLE; pending flag 0.
- States: IDLE=0, LOAD=1, WAIT_FFT=2, UNLOAD=3, REPORT=4.
- IDLE -> LOAD when enable_i && (buffer_ready_i || pending). Starting from pending clears pending.
- LOAD handshake, combinational pass-through:
  - ram_ready_o = LOAD && fft_in_ready_i.
  - fft_in_valid_o = LOAD && ram_valid_i.
  - A transfer occurs when ram_valid_i && ram_ready_o. The sample counter increments on each transfer.
  - The FFT_SIZE-th transfer moves to WAIT_FFT and clears the counter and the watchdog.
- WAIT_FFT: fft_out_ready_o=0; the watchdog increments each cycle.
  - fft_out_valid_i -> UNLOAD on the next cycle; that bin is not yet consumed.
  - Watchdog reaching TIMEOUT_CYC -> set timeout_o, go to IDLE. The frame is not counted and peak outputs are unchanged.
- UNLOAD: fft_out_ready_o=1. Each accepted bin increments the bin counter.
  - Only bins 0..FFT_SIZE/2-1 are candidates; bin 0 is excluded when SKIP_DC=1.
  - The running peak updates on strictly greater magnitude, so ties keep the lower bin.
  - The running peak resets to 0 / bin 0 on entry to LOAD.
  - After bin FFT_SIZE-1 is accepted -> REPORT.
- REPORT (1 cycle):
  - Register the running peak into peak_bin_o/peak_mag_o, pulse frame_done_o, frame_count_o+1 (wraps at 65535->0).
  - Next state: LOAD if enable_i && (pending || buffer_ready_i), else IDLE.
- Buffer arrival while not idle:
  - buffer_ready_i in LOAD/WAIT_FFT/UNLOAD/REPORT with pending=0 -> set pending.
  - With pending=1 -> drop_count_o+1 (saturating).
  - In REPORT, a buffer_ready_i that is used directly to start LOAD is neither queued nor dropped.
- enable_i low: the current frame completes. buffer_ready_i in IDLE is ignored and not counted. An existing pending flag is retained.
- Magnitude: L1 approximation |re|+|im|, MAG_W = DATA_WIDTH+1 unsigned. abs of the most negative value = 2^(DATA_WIDTH-1), computed without overflow. Combinational, no added latency.
- timeout_o clears only on reset.
- rst_i mid-frame returns immediately to reset values. The RAM and FFT handshakes deassert in the same cycle, since they are combinational from state.

Optional Feature:
MAG_SQ_EN:
- Defined: magnitude = re*re + im*im, MAG_W = 2*DATA_WIDTH+1. The magnitude is registered one stage, so each bin's compare lands one cycle later, and REPORT waits one extra cycle for the last bin's compare.
- Undefined: L1 magnitude, no multipliers, behaviour as above.

Decomposition:
- Package fft_ctrl_pkg:
  - state enum ctrl_state_e with the encodings above
  - MAG_W localparam function of DATA_WIDTH and MAG_SQ_EN
  - DROP_MAX = 255
- Sub-module fft_mag_calc: re/im in, magnitude out. Combinational L1 form, or the registered squared form under MAG_SQ_EN.

Test Plan:
- Normal frame:
  - Stimulus: buffer_ready_i pulse, 256 RAM samples at full rate, then FFT bins with bin 37 = (1000,-500) and all others (10,10).
  - Required: peak_bin_o=37, peak_mag_o=1500, one frame_done_o pulse, frame_count_o=1.
- Backpressure:
  - Stimulus: fft_in_ready_i toggling every other cycle, RAM valid gapped.
  - Required: exactly 256 transfers, no duplicated or lost samples; ram_ready_o never high outside LOAD.
- Pending and drop:
  - Stimulus: three buffer_ready_i pulses during UNLOAD.
  - Required: pending set once, drop_count_o=2, and the next frame starts directly from REPORT.
- DC, tie and Nyquist:
  - Stimulus: bin 0 = max, bins 5 and 9 tied, bin 200 larger than both.
  - Required: with SKIP_DC=1, peak_bin_o=5.
- Timeout:
  - Stimulus: TIMEOUT_CYC=100, no fft_out_valid_i after LOAD.
  - Required: timeout_o=1 after 100 cycles, state_o=0, frame_count_o unchanged.
- Reset:
  - Stimulus: rst_i asserted mid-UNLOAD at bin 60.
  - Required: all outputs 0 immediately; a subsequent full frame completes with correct results.

Source files
------------

// File: rtl/fft_ctrl_pkg.sv
// Shared types and sizing for the FFT frame sequencer.
// MAG_SQ_EN selects the squared magnitude width instead of the L1 width.
package fft_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_WAIT_FFT = 3'd2,
        ST_UNLOAD   = 3'd3,
        ST_REPORT   = 3'd4
    } ctrl_state_e;

    localparam int unsigned DATA_WIDTH_DEF = 24;
    localparam int unsigned DROP_MAX       = 255;

    function automatic int unsigned mag_width(input int unsigned dw);
`ifdef MAG_SQ_EN
        return 2 * dw + 1;
`else
        return dw + 1;
`endif
    endfunction

    localparam int unsigned MAG_W = mag_width(DATA_WIDTH_DEF);

endpackage

// File: rtl/fft_frame_ctrl_if.sv
// RAM-read and FFT-core handshake bundle seen by the frame sequencer.
// master = sequencer side, slave = RAM/FFT side.
interface fft_frame_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 24
);
    logic                         ram_valid_i;
    logic                         ram_ready_o;
    logic                         fft_in_valid_o;
    logic                         fft_in_ready_i;
    logic                         fft_out_valid_i;
    logic                         fft_out_ready_o;
    logic signed [DATA_WIDTH-1:0] fft_real_i;
    logic signed [DATA_WIDTH-1:0] fft_imag_i;

    modport master (
        input  ram_valid_i, fft_in_ready_i, fft_out_valid_i, fft_real_i, fft_imag_i,
        output ram_ready_o, fft_in_valid_o, fft_out_ready_o
    );

    modport slave (
        output ram_valid_i, fft_in_ready_i, fft_out_valid_i, fft_real_i, fft_imag_i,
        input  ram_ready_o, fft_in_valid_o, fft_out_ready_o
    );
endinterface

// File: rtl/fft_mag_calc.sv
// Per-bin magnitude: combinational |re|+|im|, or registered re^2+im^2 when MAG_SQ_EN is defined.
module fft_mag_calc
    import fft_ctrl_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 24,
    localparam int unsigned MW         = mag_width(DATA_WIDTH)
) (
`ifdef MAG_SQ_EN
    input  logic                         clk,
    input  logic                         rst,
`endif
    input  logic signed [DATA_WIDTH-1:0] re,
    input  logic signed [DATA_WIDTH-1:0] im,
    output logic        [MW-1:0]         mag
);

`ifdef MAG_SQ_EN
    logic signed [2*DATA_WIDTH-1:0] re_sq;
    logic signed [2*DATA_WIDTH-1:0] im_sq;

    assign re_sq = re * re;
    assign im_sq = im * im;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag <= '0;
        end else begin
            mag <= MW'($unsigned(re_sq)) + MW'($unsigned(im_sq));
        end
    end
`else
    logic [DATA_WIDTH-1:0] re_abs;
    logic [DATA_WIDTH-1:0] im_abs;

    // Negating the most negative value wraps to 2^(W-1), which is exact when read unsigned.
    assign re_abs = re[DATA_WIDTH-1] ? DATA_WIDTH'($unsigned(-re)) : DATA_WIDTH'($unsigned(re));
    assign im_abs = im[DATA_WIDTH-1] ? DATA_WIDTH'($unsigned(-im)) : DATA_WIDTH'($unsigned(im));
    assign mag    = MW'(re_abs) + MW'(im_abs);
`endif

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer: RAM -> FFT load, bin drain with peak search, pending/drop and watchdog.
// Define MAG_SQ_EN for the squared magnitude (one extra compare stage and REPORT cycle).
module fft_frame_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH  = 24,
    parameter  int unsigned FFT_SIZE    = 256,
    parameter  int unsigned BIN_W       = 8,
    parameter  int unsigned SKIP_DC     = 1,
    parameter  int unsigned TIMEOUT_CYC = 65535,
    localparam int unsigned MW          = mag_width(DATA_WIDTH)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               enable_i,
    input  logic               buffer_ready_i,
    fft_frame_ctrl_if.master   bus,
    output logic [BIN_W-1:0]   peak_bin_o,
    output logic [MW-1:0]      peak_mag_o,
    output logic               frame_done_o,
    output logic [15:0]        frame_count_o,
    output logic [7:0]         drop_count_o,
    output logic               timeout_o,
    output logic [2:0]         state_o
);

    localparam int unsigned      WD_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [BIN_W-1:0] LAST_IDX = BIN_W'(FFT_SIZE - 1);
    localparam logic [BIN_W-1:0] HALF     = BIN_W'(FFT_SIZE / 2);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);

    ctrl_state_e      state;
    logic             pending;
    logic [BIN_W-1:0] cnt;
    logic [WD_W-1:0]  wdog;
    logic [BIN_W-1:0] run_bin;
    logic [MW-1:0]    run_mag;
    logic [MW-1:0]    mag;
    logic             ram_ready;
    logic             xfer;
    logic             bin_acc;
    logic             cand;
    logic             cmp_vld;
    logic [BIN_W-1:0] cmp_bin;
    logic             rpt_go;
    logic             start_direct;

    // Handshakes are pure functions of state so reset drops them immediately.
    assign ram_ready           = (state == ST_LOAD) && bus.fft_in_ready_i;
    assign bus.ram_ready_o     = ram_ready;
    assign bus.fft_in_valid_o  = (state == ST_LOAD) && bus.ram_valid_i;
    assign bus.fft_out_ready_o = (state == ST_UNLOAD);
    assign state_o             = state;

    assign xfer    = bus.ram_valid_i && ram_ready;
    assign bin_acc = (state == ST_UNLOAD) && bus.fft_out_valid_i;
    assign cand    = bin_acc && (cnt < HALF) && ((SKIP_DC == 0) || (cnt != '0));

    fft_mag_calc #(.DATA_WIDTH(DATA_WIDTH)) u_mag (
`ifdef MAG_SQ_EN
        .clk (clk_i),
        .rst (rst_i),
`endif
        .re  (bus.fft_real_i),
        .im  (bus.fft_imag_i),
        .mag (mag)
    );

`ifdef MAG_SQ_EN
    logic             cand_q;
    logic [BIN_W-1:0] cnt_q;
    logic             rpt_wait;

    // Align candidate flag and bin index with the registered magnitude.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cand_q   <= 1'b0;
            cnt_q    <= '0;
            rpt_wait <= 1'b0;
        end else begin
            cand_q   <= cand;
            cnt_q    <= cnt;
            rpt_wait <= (state == ST_REPORT) && !rpt_wait;
        end
    end

    assign cmp_vld = cand_q;
    assign cmp_bin = cnt_q;
    assign rpt_go  = rpt_wait;
`else
    assign cmp_vld = cand;
    assign cmp_bin = cnt;
    assign rpt_go  = 1'b1;
`endif

    // A buffer that launches the next frame straight out of REPORT is neither queued nor dropped.
    assign start_direct = (state == ST_REPORT) && rpt_go && enable_i && !pending;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= ST_IDLE;
            pending       <= 1'b0;
            cnt           <= '0;
            wdog          <= '0;
            run_bin       <= '0;
            run_mag       <= '0;
            peak_bin_o    <= '0;
            peak_mag_o    <= '0;
            frame_done_o  <= 1'b0;
            frame_count_o <= '0;
            drop_count_o  <= '0;
            timeout_o     <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;

            // Strictly-greater update keeps the lower bin on ties.
            if (cmp_vld && (mag > run_mag)) begin
                run_mag <= mag;
                run_bin <= cmp_bin;
            end

            if (buffer_ready_i && (state != ST_IDLE) && !start_direct) begin
                if (!pending) begin
                    pending <= 1'b1;
                end else if (drop_count_o != 8'(DROP_MAX)) begin
                    drop_count_o <= drop_count_o + 8'd1;
                end
            end

            unique case (state)
                ST_IDLE: begin
                    if (enable_i && (buffer_ready_i || pending)) begin
                        state   <= ST_LOAD;
                        pending <= 1'b0;
                        cnt     <= '0;
                        run_mag <= '0;
                        run_bin <= '0;
                    end
                end
                ST_LOAD: begin
                    if (xfer) begin
                        if (cnt == LAST_IDX) begin
                            cnt   <= '0;
                            wdog  <= '0;
                            state <= ST_WAIT_FFT;
                        end else begin
                            cnt <= cnt + BIN_W'(1);
                        end
                    end
                end
                ST_WAIT_FFT: begin
                    if (bus.fft_out_valid_i) begin
                        state <= ST_UNLOAD;
                    end else if (wdog == WD_LAST) begin
                        timeout_o <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        wdog <= wdog + WD_W'(1);
                    end
                end
                ST_UNLOAD: begin
                    if (bin_acc) begin
                        if (cnt == LAST_IDX) begin
                            cnt   <= '0;
                            state <= ST_REPORT;
                        end else begin
                            cnt <= cnt + BIN_W'(1);
                        end
                    end
                end
                ST_REPORT: begin
                    if (rpt_go) begin
                        peak_bin_o    <= run_bin;
                        peak_mag_o    <= run_mag;
                        frame_done_o  <= 1'b1;
                        frame_count_o <= frame_count_o + 16'd1;
                        if (enable_i && (pending || buffer_ready_i)) begin
                            state   <= ST_LOAD;
                            pending <= 1'b0;
                            cnt     <= '0;
                            run_mag <= '0;
                            run_bin <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Self-checking bench for fft_frame_ctrl: scoreboard of expected peaks checked on each frame_done.
module tb_fft_frame_ctrl;
    import fft_ctrl_pkg::*;

    localparam int unsigned DW     = 24;
    localparam int unsigned NB     = 256;
    localparam int unsigned MW     = mag_width(DW);
    localparam int unsigned TO_CYC = 100;

    typedef struct {
        longint bin;
        longint mag;
        longint fc;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          enable;
    logic          buffer_ready;
    logic [7:0]    peak_bin;
    logic [MW-1:0] peak_mag;
    logic          frame_done;
    logic [15:0]   frame_count;
    logic [7:0]    drop_count;
    logic          timeout;
    logic [2:0]    state_o;

    fft_frame_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    fft_frame_ctrl #(
        .DATA_WIDTH (DW),
        .FFT_SIZE   (NB),
        .BIN_W      (8),
        .SKIP_DC    (1),
        .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .enable_i       (enable),
        .buffer_ready_i (buffer_ready),
        .bus            (bus),
        .peak_bin_o     (peak_bin),
        .peak_mag_o     (peak_mag),
        .frame_done_o   (frame_done),
        .frame_count_o  (frame_count),
        .drop_count_o   (drop_count),
        .timeout_o      (timeout),
        .state_o        (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_err = 0;
    int   viol = 0;
    int   done_seen = 0;
    int   n_pushed = 0;
    int   model_fc = 0;
    exp_t last_exp;
    exp_t mon_e;
    exp_t exp_q[$];
    int   bin_re[NB];
    int   bin_im[NB];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Handshake legality and scoreboard pop, sampled away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ram_ready_o && state_o != 3'd1) viol++;
            if (bus.fft_in_valid_o && state_o != 3'd1) viol++;
            if (bus.fft_out_ready_o && state_o != 3'd3) viol++;
            if (state_o == 3'd1 && bus.fft_in_valid_o != bus.ram_valid_i) viol++;
            if (frame_done) begin
                done_seen++;
                check_val("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check_val("peak_bin", 64'(peak_bin), 64'(mon_e.bin));
                    check_val("peak_mag", 64'(peak_mag), 64'(mon_e.mag));
                    check_val("frame_count", 64'(frame_count), 64'(mon_e.fc));
                end
            end
        end
    end

    function automatic longint mag_of(input int re, input int im);
        longint r;
        longint i;
        r = re;
        i = im;
`ifdef MAG_SQ_EN
        return r * r + i * i;
`else
        return (r < 0 ? -r : r) + (i < 0 ? -i : i);
`endif
    endfunction

    task automatic push_expected();
        exp_t   e;
        longint m;
        e.bin = 0;
        e.mag = 0;
        for (int b = 1; b < NB / 2; b++) begin
            m = mag_of(bin_re[b], bin_im[b]);
            if (m > e.mag) begin
                e.mag = m;
                e.bin = b;
            end
        end
        model_fc = (model_fc + 1) % 65536;
        e.fc     = model_fc;
        last_exp = e;
        n_pushed++;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_buf();
        buffer_ready = 1'b1;
        tick();
        buffer_ready = 1'b0;
    endtask

    task automatic set_bins(input int re, input int im);
        for (int b = 0; b < NB; b++) begin
            bin_re[b] = re;
            bin_im[b] = im;
        end
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_state"}, 64'(state_o), 64'd0);
        check_val({tag, "_ram_ready"}, 64'(bus.ram_ready_o), 64'd0);
        check_val({tag, "_fft_in_valid"}, 64'(bus.fft_in_valid_o), 64'd0);
        check_val({tag, "_fft_out_ready"}, 64'(bus.fft_out_ready_o), 64'd0);
        check_val({tag, "_peak_bin"}, 64'(peak_bin), 64'd0);
        check_val({tag, "_peak_mag"}, 64'(peak_mag), 64'd0);
        check_val({tag, "_frame_done"}, 64'(frame_done), 64'd0);
        check_val({tag, "_frame_count"}, 64'(frame_count), 64'd0);
        check_val({tag, "_drop_count"}, 64'(drop_count), 64'd0);
        check_val({tag, "_timeout"}, 64'(timeout), 64'd0);
    endtask

    task automatic run_load(input bit gapped, input string tag);
        int n   = 0;
        int cyc = 0;
        int bad = 0;
        check_val({tag, "_in_load"}, 64'(state_o), 64'd1);
        while (n < NB && cyc < 5000) begin
            bus.fft_in_ready_i = gapped ? cyc[0] : 1'b1;
            bus.ram_valid_i    = gapped ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(negedge clk);
            if (state_o != 3'd1) bad++;
            if (bus.ram_valid_i && bus.ram_ready_o) n++;
            tick();
            cyc++;
        end
        bus.ram_valid_i    = 1'b0;
        bus.fft_in_ready_i = 1'b0;
        check_val({tag, "_xfers"}, 64'(n), 64'(NB));
        check_val({tag, "_left_load_early"}, 64'(bad), 64'd0);
        check_val({tag, "_in_wait"}, 64'(state_o), 64'd2);
    endtask

    task automatic run_unload(input bit gapped, input int n_pulses, input int abort_at);
        int idx  = 0;
        int cyc  = 0;
        int left = n_pulses;
        if (abort_at < 0) push_expected();
        while (idx < NB && cyc < 5000) begin
            if (idx == abort_at) return;
            bus.fft_out_valid_i = gapped ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.fft_real_i      = DW'(bin_re[idx]);
            bus.fft_imag_i      = DW'(bin_im[idx]);
            buffer_ready        = (left > 0) && (idx >= 10 * (n_pulses - left + 1));
            if (buffer_ready) left--;
            @(negedge clk);
            if (bus.fft_out_valid_i && bus.fft_out_ready_o) idx++;
            tick();
            cyc++;
        end
        bus.fft_out_valid_i = 1'b0;
        buffer_ready        = 1'b0;
        check_val("unload_bins", 64'(idx), 64'(NB));
    endtask

    task automatic wait_done(input logic [2:0] st_exp, input string tag);
        int cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!frame_done && cyc < 50);
        check_val({tag, "_done_seen"}, 64'(frame_done), 64'd1);
        check_val({tag, "_state_after"}, 64'(state_o), 64'(st_exp));
        tick();
        check_val({tag, "_done_pulse_len"}, 64'(frame_done), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int w;
        int cyc;
        rst                 = 1'b1;
        enable              = 1'b0;
        buffer_ready        = 1'b0;
        bus.ram_valid_i     = 1'b0;
        bus.fft_in_ready_i  = 1'b0;
        bus.fft_out_valid_i = 1'b0;
        bus.fft_real_i      = '0;
        bus.fft_imag_i      = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        tick();
        enable = 1'b1;

        // Normal frame with a single dominant bin
        set_bins(10, 10);
        bin_re[37] = 1000;
        bin_im[37] = -500;
        pulse_buf();
        run_load(1'b0, "norm");
        run_unload(1'b0, 0, -1);
        wait_done(3'd0, "norm");
`ifndef MAG_SQ_EN
        check_val("norm_peak_bin", 64'(peak_bin), 64'd37);
        check_val("norm_peak_mag", 64'(peak_mag), 64'd1500);
`endif
        check_val("norm_frame_count", 64'(frame_count), 64'd1);

        // Backpressured load, gapped bins, random spectrum
        for (int b = 0; b < NB; b++) begin
            bin_re[b] = int'($urandom_range(0, 4000)) - 2000;
            bin_im[b] = int'($urandom_range(0, 4000)) - 2000;
        end
        pulse_buf();
        run_load(1'b1, "bp");
        run_unload(1'b1, 0, -1);
        wait_done(3'd0, "bp");

        // DC excluded, tie keeps lower bin, upper half ignored
        set_bins(1, 1);
        bin_re[0]   = 5000;  bin_im[0]   = 5000;
        bin_re[5]   = 300;   bin_im[5]   = -200;
        bin_re[9]   = -250;  bin_im[9]   = 250;
        bin_re[128] = 7000;  bin_im[128] = 0;
        bin_re[200] = 9000;  bin_im[200] = 9000;
        pulse_buf();
        run_load(1'b0, "tie");
        run_unload(1'b0, 0, -1);
        wait_done(3'd0, "tie");
        check_val("tie_peak_bin", 64'(peak_bin), 64'd5);

        // Most negative inputs on both parts
        set_bins(3, -3);
        bin_re[100] = -(1 << 23);
        bin_im[100] = -(1 << 23);
        bin_re[127] = 100;
        bin_im[127] = 0;
        pulse_buf();
        run_load(1'b0, "minval");
        run_unload(1'b0, 0, -1);
        wait_done(3'd0, "minval");

        // Three buffers during UNLOAD: one pending, two dropped
        set_bins(10, 10);
        bin_re[60] = 777;
        pulse_buf();
        run_load(1'b0, "pend");
        run_unload(1'b0, 3, -1);
        check_val("pend_drop_count", 64'(drop_count), 64'd2);
        wait_done(3'd1, "pend");
        run_load(1'b0, "pend2");
        run_unload(1'b0, 0, -1);
        wait_done(3'd0, "pend2");
        check_val("pend2_drop_count", 64'(drop_count), 64'd2);

        // Watchdog: FFT never produces output
        pulse_buf();
        run_load(1'b0, "to");
        w   = 0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (!timeout && state_o == 3'd2) w++;
        end while (!timeout && cyc < 1000);
        check_val("to_flag", 64'(timeout), 64'd1);
        check_val("to_wait_cycles", 64'(w), 64'(TO_CYC));
        check_val("to_state", 64'(state_o), 64'd0);
        check_val("to_frame_count", 64'(frame_count), 64'(model_fc));
        check_val("to_peak_bin", 64'(peak_bin), 64'(last_exp.bin));
        tick();

        // Reset in the middle of UNLOAD
        set_bins(10, 10);
        bin_re[50] = 400;
        bin_im[50] = 400;
        pulse_buf();
        run_load(1'b0, "rst");
        run_unload(1'b0, 0, 60);
        check_val("rst_mid_unload", 64'(state_o), 64'd3);
        rst = 1'b1;
        #1;
        check_zero("midrst");
        bus.fft_out_valid_i = 1'b0;
        model_fc = 0;
        tick();
        rst = 1'b0;
        tick();
        pulse_buf();
        run_load(1'b0, "post");
        run_unload(1'b0, 0, -1);
        wait_done(3'd0, "post");
        check_val("post_frame_count", 64'(frame_count), 64'd1);
        check_val("post_peak_bin", 64'(peak_bin), 64'd50);

        check_val("handshake_violations", 64'(viol), 64'd0);
        check_val("sb_drained", 64'(exp_q.size()), 64'd0);
        check_val("frames_seen", 64'(done_seen), 64'(n_pushed));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
